// File: rtl/axi_chan_buffer.sv
// rtl/axi_chan_buffer.sv - elastic AXI channel buffer with registered outputs; optional FLUSH via AXI_CHAN_BUFFER_FLUSH_EN
module axi_chan_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
`ifdef AXI_CHAN_BUFFER_FLUSH_EN
    input  logic                         FLUSH,
`endif
    input  logic [DATA_WIDTH-1:0]        S_DATA,
    input  logic                         S_LAST,
    input  logic                         S_VALID,
    output logic                         S_READY,
    output logic [DATA_WIDTH-1:0]        M_DATA,
    output logic                         M_LAST,
    output logic                         M_VALID,
    input  logic                         M_READY,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
    output logic [$clog2(DEPTH+1)-1:0]   PKT_CNT
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {HOLD, RELEASE} state_t;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       ram_cnt;
    state_t              state, state_next;
    logic                clr;
    logic                push, pop, out_free, load_ok, load_ram, bypass;
    logic                go_release, ret_hold;
    logic [LW-1:0]       level_next, pkt_next;

`ifdef AXI_CHAN_BUFFER_FLUSH_EN
    assign clr     = RST || FLUSH;
    assign S_READY = !RST && ((LEVEL < LW'(DEPTH)) || FLUSH);
`else
    assign clr     = RST;
    assign S_READY = !RST && (LEVEL < LW'(DEPTH));
`endif

    always_comb begin
        push       = S_VALID && S_READY;
        pop        = M_VALID && M_READY;
        level_next = LEVEL + LW'(push) - LW'(pop);
        pkt_next   = PKT_CNT + LW'(push && S_LAST) - LW'(pop && M_LAST);
        // HOLD leaves at the same edge it sees a stored LAST (or full), so packet latency matches cut-through
        go_release = (state == RELEASE) || (PKT_CNT != '0) || (LEVEL == LW'(DEPTH));
        ret_hold   = pop && M_LAST && (pkt_next == '0) && (level_next < LW'(DEPTH));
        load_ok    = (PACKET_MODE == 0) || (go_release && !ret_hold);
        state_next = HOLD;
        if (PACKET_MODE != 0 && go_release && !ret_hold)
            state_next = RELEASE;
        out_free   = !M_VALID || pop;
        load_ram   = load_ok && out_free && (ram_cnt != '0);
        // only a word replacing one being popped skips the RAM; an empty buffer still takes one cycle
        bypass     = load_ok && pop && push && (ram_cnt == '0);
    end

    always_ff @(posedge CLK) begin
        if (!clr && push && !bypass)
            mem[wr_ptr] <= {S_LAST, S_DATA};
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            state   <= HOLD;
            LEVEL   <= '0;
            PKT_CNT <= '0;
            M_VALID <= 1'b0;
            M_DATA  <= '0;
            M_LAST  <= 1'b0;
        end else begin
            state   <= state_next;
            LEVEL   <= level_next;
            PKT_CNT <= pkt_next;
            if (push && !bypass)
                wr_ptr <= wr_ptr + 1'b1;
            if (load_ram)
                rd_ptr <= rd_ptr + 1'b1;
            ram_cnt <= ram_cnt + LW'(push && !bypass) - LW'(load_ram);
            if (load_ram)
                {M_LAST, M_DATA} <= mem[rd_ptr];
            else if (bypass)
                {M_LAST, M_DATA} <= {S_LAST, S_DATA};
            M_VALID <= load_ram || bypass || (M_VALID && !pop);
        end
    end

endmodule

// File: tb/tb_axi_chan_buffer.sv
// tb/tb_axi_chan_buffer.sv - randomized queue-model bench for axi_chan_buffer in cut-through and packet modes
module tb_axi_chan_buffer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] s_data [2];
    logic        s_last [2];
    logic        s_valid[2];
    logic        s_ready[2];
    logic [31:0] m_data [2];
    logic        m_last [2];
    logic        m_valid[2];
    logic        m_ready[2];
    logic [4:0]  level  [2];
    logic [4:0]  pkt    [2];
`ifdef AXI_CHAN_BUFFER_FLUSH_EN
    logic        flush  [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    axi_chan_buffer #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) dut0 (
        .CLK(CLK), .RST(RST),
`ifdef AXI_CHAN_BUFFER_FLUSH_EN
        .FLUSH(flush[0]),
`endif
        .S_DATA(s_data[0]), .S_LAST(s_last[0]), .S_VALID(s_valid[0]), .S_READY(s_ready[0]),
        .M_DATA(m_data[0]), .M_LAST(m_last[0]), .M_VALID(m_valid[0]), .M_READY(m_ready[0]),
        .LEVEL(level[0]), .PKT_CNT(pkt[0]));

    axi_chan_buffer #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(1)) dut1 (
        .CLK(CLK), .RST(RST),
`ifdef AXI_CHAN_BUFFER_FLUSH_EN
        .FLUSH(flush[1]),
`endif
        .S_DATA(s_data[1]), .S_LAST(s_last[1]), .S_VALID(s_valid[1]), .S_READY(s_ready[1]),
        .M_DATA(m_data[1]), .M_LAST(m_last[1]), .M_VALID(m_valid[1]), .M_READY(m_ready[1]),
        .LEVEL(level[1]), .PKT_CNT(pkt[1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each DUT is a FIFO queue of {last,data}; the head is what M_DATA must show.
    logic [32:0] mq [2][0:255];
    int          head[2], tail[2], pops[2];
    logic        mvm0;
    logic        prev_mv[2], prev_pop[2];
    bit          mon_en = 0;

    always @(negedge CLK) begin
        int   sz, lc;
        logic mv, push, pop, exp_rdy, clr;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                sz = tail[d] - head[d];
                lc = 0;
                for (int k = head[d]; k < tail[d]; k++) lc += int'(mq[d][k & 255][32]);
                check("level", 64'(level[d]), 64'(sz));
                check("pkt_cnt", 64'(pkt[d]), 64'(lc));
`ifdef AXI_CHAN_BUFFER_FLUSH_EN
                exp_rdy = !RST && ((sz < 16) || flush[d]);
                clr     = RST || flush[d];
`else
                exp_rdy = !RST && (sz < 16);
                clr     = RST;
`endif
                check("s_ready", 64'(s_ready[d]), 64'(exp_rdy));
                if (d == 0) check("m_valid", 64'(m_valid[0]), 64'(mvm0));
                mv = (d == 0) ? mvm0 : m_valid[1];
                if (prev_mv[d] && !prev_pop[d]) check("m_valid_hold", 64'(m_valid[d]), 64'd1);
                if (mv) begin
                    if (sz == 0) check("m_valid_empty", 64'd0, 64'd1);
                    else check("m_data", 64'({m_last[d], m_data[d]}), 64'(mq[d][head[d] & 255]));
                end
                if (d == 1 && mv && !prev_mv[1])
                    check("pkt_gate", 64'((lc > 0) || (sz == 16)), 64'd1);
                push = s_valid[d] && exp_rdy;
                pop  = mv && m_ready[d];
                if (clr) begin
                    head[d] = tail[d];
                    if (d == 0) mvm0 = 1'b0;
                    prev_mv[d]  = 1'b0;
                    prev_pop[d] = 1'b0;
                end else begin
                    // output register fills if it keeps its word, stored words wait behind it, or a pop is refilled by a push
                    if (d == 0)
                        mvm0 = (mvm0 && !pop) || ((sz - int'(mvm0)) > 0) || (mvm0 && pop && push);
                    if (pop) begin
                        head[d]++;
                        pops[d]++;
                    end
                    if (push) begin
                        mq[d][tail[d] & 255] = {s_last[d], s_data[d]};
                        tail[d]++;
                    end
                    prev_mv[d]  = mv;
                    prev_pop[d] = pop;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int d, input logic [31:0] data, input logic last);
        logic hs;
        int   n;
        s_valid[d] = 1'b1;
        s_data[d]  = data;
        s_last[d]  = last;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            hs = s_ready[d];
            step();
            n++;
        end
        if (!hs) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            s_data[d]  = '0;
            s_last[d]  = 1'b0;
            m_ready[d] = 1'b0;
        end
        RST = 1'b1;
        step();
        mon_en = 1;
        step();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        int   p0, rem, lvl_min, lvl_max, bubbles;
        logic hs, seen, early;
`ifdef AXI_CHAN_BUFFER_FLUSH_EN
        flush[0] = 1'b0;
        flush[1] = 1'b0;
`endif
        head = '{0, 0}; tail = '{0, 0}; pops = '{0, 0};
        mvm0 = 1'b0;
        prev_mv = '{1'b0, 1'b0}; prev_pop = '{1'b0, 1'b0};
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0; s_data[d] = '0; s_last[d] = 1'b0; m_ready[d] = 1'b0;
        end
        step();
        RST = 1'b1;
        step();
        mon_en = 1;
        check("rst_m_valid", 64'(m_valid[0]), 64'd0);
        check("rst_m_data", 64'(m_data[0]), 64'd0);
        check("rst_m_last", 64'(m_last[0]), 64'd0);
        check("rst_level", 64'(level[0]), 64'd0);
        check("rst_pkt", 64'(pkt[0]), 64'd0);
        check("rst_s_ready", 64'(s_ready[0]), 64'd0);
        RST = 1'b0;
        #1;
        check("rst_fall_s_ready", 64'(s_ready[0]), 64'd1);

        // single word latency
        m_ready[0] = 1'b1;
        send(0, 32'h11, 1'b1);
        s_valid[0] = 1'b0;
        check("t1_wait_valid", 64'(m_valid[0]), 64'd0);
        check("t1_level", 64'(level[0]), 64'd1);
        step();
        check("t1_valid", 64'(m_valid[0]), 64'd1);
        check("t1_data", 64'(m_data[0]), 64'h11);
        step();
        check("t1_level_after", 64'(level[0]), 64'd0);

        // fill to full, then drain
        m_ready[0] = 1'b0;
        p0 = pops[0];
        for (int i = 0; i < 16; i++) send(0, i, 1'b0);
        check("t2_full_ready", 64'(s_ready[0]), 64'd0);
        check("t2_full_level", 64'(level[0]), 64'd16);
        check("t2_head_data", 64'(m_data[0]), 64'd0);
        m_ready[0] = 1'b1;
        for (int i = 16; i < 20; i++) send(0, i, 1'b0);
        s_valid[0] = 1'b0;
        repeat (30) step();
        check("t2_drained", 64'(pops[0] - p0), 64'd20);

        // full-rate streaming
        p0 = pops[0];
        seen = 1'b0; bubbles = 0; lvl_min = 99; lvl_max = -1;
        for (int i = 0; i < 100; i++) begin
            send(0, 32'h1000 + i, 1'($urandom_range(0, 1)));
            if (m_valid[0]) seen = 1'b1;
            else if (seen) bubbles++;
            if (seen) begin
                if (int'(level[0]) < lvl_min) lvl_min = int'(level[0]);
                if (int'(level[0]) > lvl_max) lvl_max = int'(level[0]);
            end
        end
        s_valid[0] = 1'b0;
        repeat (10) step();
        check("t3_bubbles", 64'(bubbles), 64'd0);
        check("t3_level_const", 64'(lvl_max - lvl_min), 64'd0);
        check("t3_count", 64'(pops[0] - p0), 64'd100);

        // random cut-through traffic
        hs = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!s_valid[0] || hs) begin
                s_valid[0] = ($urandom_range(0, 9) < 7);
                s_data[0]  = $urandom;
                s_last[0]  = 1'($urandom_range(0, 1));
            end
            m_ready[0] = ($urandom_range(0, 9) < 6);
            hs = s_valid[0] && s_ready[0];
            step();
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        repeat (20) step();
        check("rand0_drained", 64'(level[0]), 64'd0);

        // packet mode: gapped 4-word burst
        do_reset();
        m_ready[1] = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1, 32'h40 + i, 1'(i == 3));
            s_valid[1] = 1'b0;
            early |= m_valid[1];
            if (i < 3) repeat (2) begin
                step();
                early |= m_valid[1];
            end
        end
        check("t4_held", 64'(early), 64'd0);
        check("t4_pkt_one", 64'(pkt[1]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_burst_valid", 64'(m_valid[1]), 64'd1);
            check("t4_burst_data", 64'(m_data[1]), 64'(32'h40 + k));
        end
        step();
        check("t4_done_valid", 64'(m_valid[1]), 64'd0);
        check("t4_pkt_zero", 64'(pkt[1]), 64'd0);

        // packet mode: burst longer than the buffer escapes via full
        do_reset();
        p0 = pops[1];
        for (int i = 0; i < 16; i++) send(1, 100 + i, 1'b0);
        check("t5_full_level", 64'(level[1]), 64'd16);
        check("t5_full_ready", 64'(s_ready[1]), 64'd0);
        step();
        check("t5_escape_valid", 64'(m_valid[1]), 64'd1);
        check("t5_escape_data", 64'(m_data[1]), 64'd100);
        m_ready[1] = 1'b1;
        for (int i = 16; i < 20; i++) send(1, 100 + i, 1'(i == 19));
        s_valid[1] = 1'b0;
        repeat (30) step();
        check("t5_long_count", 64'(pops[1] - p0), 64'd20);
        send(1, 200, 1'b0);
        s_valid[1] = 1'b0;
        early = 1'b0;
        repeat (3) begin
            step();
            early |= m_valid[1];
        end
        check("t5_short_held", 64'(early | m_valid[1]), 64'd0);
        send(1, 201, 1'b1);
        s_valid[1] = 1'b0;
        step();
        check("t5_short_valid", 64'(m_valid[1]), 64'd1);
        check("t5_short_data", 64'(m_data[1]), 64'd200);
        repeat (4) step();

        // random packet traffic, bursts 1..6
        hs = 1'b0; rem = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!s_valid[1] || hs) begin
                if ($urandom_range(0, 9) < 7) begin
                    if (rem == 0) rem = $urandom_range(1, 6);
                    s_data[1]  = $urandom;
                    s_last[1]  = (rem == 1);
                    rem--;
                    s_valid[1] = 1'b1;
                end else begin
                    s_valid[1] = 1'b0;
                end
            end
            m_ready[1] = ($urandom_range(0, 9) < 6);
            hs = s_valid[1] && s_ready[1];
            step();
        end
        if (s_valid[1] && !hs) send(1, s_data[1], s_last[1]);
        while (rem > 0) begin
            send(1, $urandom, 1'(rem == 1));
            rem--;
        end
        s_valid[1] = 1'b0;
        m_ready[1] = 1'b1;
        repeat (30) step();
        check("rand1_drained", 64'(level[1]), 64'd0);

        // reset mid-burst
        do_reset();
        for (int i = 0; i < 7; i++) send(0, 32'h700 + i, 1'b0);
        check("t6_level7", 64'(level[0]), 64'd7);
        RST = 1'b1;
        step();
        check("t6_level", 64'(level[0]), 64'd0);
        check("t6_valid", 64'(m_valid[0]), 64'd0);
        check("t6_ready", 64'(s_ready[0]), 64'd0);
        RST = 1'b0;
        s_valid[0] = 1'b0;
        #1;
        check("t6_ready_after", 64'(s_ready[0]), 64'd1);
`ifdef AXI_CHAN_BUFFER_FLUSH_EN
        for (int i = 0; i < 7; i++) send(0, 32'h800 + i, 1'b1);
        flush[0] = 1'b1;
        #1;
        check("t6f_ready_during", 64'(s_ready[0]), 64'd1);
        step();
        check("t6f_level", 64'(level[0]), 64'd0);
        check("t6f_pkt", 64'(pkt[0]), 64'd0);
        check("t6f_valid", 64'(m_valid[0]), 64'd0);
        check("t6f_ready", 64'(s_ready[0]), 64'd1);
        flush[0] = 1'b0;
        s_valid[0] = 1'b0;
        step();
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
